lcd_spi_arbiter: RTL and testbench
==================================

# lcd_spi_arbiter

Shares the single serial LCD bus (`lcd_cs`/`lcd_rs`/`lcd_data`, sampled by the panel on `lcd_clk = ~clk_27mhz`) between two requesters: a command port that carries 9-bit command/parameter words, and a pixel port that carries 16-bit RGB565 pixels. It sits between the init/window sequencer, the UART pixel assembler, and the panel pins. The block handles fixed-priority arbitration with burst locking for commands, MSB-first serialization, chip-select framing, and pixel counting after each RAMWR.

## Interface
- `WORD_GAP`, default 1: number of extra cycles with `lcd_cs` high between words (range 0–15).
- `clk_27mhz`  in  1  system clock (27 MHz).
- `resetn`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  command word offered.
- `cmd_rs`  in  1  0 = command byte, 1 = parameter byte.
- `cmd_data`  in  8  command/parameter byte.
- `cmd_last`  in  1  last word of a command burst; releases the lock.
- `cmd_ready`  out  1  command word accepted when `cmd_valid & cmd_ready`.
- `pix_valid`  in  1  pixel offered.
- `pix_data`  in  16  RGB565 pixel, sent high byte first.
- `pix_ready`  out  1  pixel accepted when `pix_valid & pix_ready`.
- `lcd_cs`  out  1  panel chip select, active-low.
- `lcd_rs`  out  1  panel data/command select.
- `lcd_data`  out  1  serial data, MSB first.
- `busy`  out  1  high in any state other than IDLE.
- `pix_cnt`  out  16  pixels sent since the last accepted RAMWR (`cmd_rs=0`, `cmd_data=8'h2C`).

## Operation
- States:
  - IDLE: arbitrate; `lcd_cs=1`.
  - SHIFT: `lcd_cs=0`; shift the word out.
  - GAP: `lcd_cs=1`; count `WORD_GAP` cycles.
- A registered `run` flag is cleared by reset and set on the first clock after `resetn` rises. Both ready outputs are 0 while `run=0`.
- `cmd_ready = run & (state==IDLE)`.
- `pix_ready = run & (state==IDLE) & ~cmd_valid & ~lock`.
- Command priority is fixed: a pixel is accepted only in a cycle where no command is offered.
- Lock:
  - Accepting a command with `cmd_last=0` sets `lock`.
  - Accepting a command with `cmd_last=1` clears `lock`.
  - While `lock=1`, pixels are stalled even if `cmd_valid=0`.
- On command acceptance, load the shift register with `cmd_data` and the bit count with 8, and register `lcd_rs=cmd_rs`.
- On pixel acceptance, load `pix_data` with a bit count of 16 and set `lcd_rs=1`.
- SHIFT: each cycle shift left with a 1 filled in, and decrement the count. When the final bit has been driven, go to GAP, or to IDLE if `WORD_GAP=0`. `lcd_cs` stays low across both bytes of a pixel.
- Leaving SHIFT drives `lcd_cs=1`, `lcd_rs=1`, `lcd_data=1`.
- `pix_cnt`:
  - Cleared on acceptance of RAMWR.
  - Incremented by 1 when a pixel's SHIFT phase completes.
  - Wraps from 16'hFFFF to 0.
- Asynchronous reset at any time, including mid-word:
  - The word in flight is abandoned, not resumed.
  - `state=IDLE`, `lock=0`, `run=0`, `pix_cnt=0`.
  - Outputs: `lcd_cs=1`, `lcd_rs=1`, `lcd_data=1`, `busy=0`, `cmd_ready=0`, `pix_ready=0`.

## Timing
- Acceptance at rising edge E0. From E0, `lcd_cs=0`, `lcd_data` carries bit 7 (command) or bit 15 (pixel), and `lcd_rs` is valid.
- Data changes on rising edges only; the panel samples on falling edges via the inverted clock.
- `lcd_cs` stays low for exactly 8 cycles (command) or 16 cycles (pixel): E0 to E8 or E0 to E16.
- After that, `lcd_cs` stays high for `WORD_GAP` cycles in GAP plus at least 1 cycle in IDLE. The next acceptance is possible at E8+`WORD_GAP`+1 (command) or E16+`WORD_GAP`+1 (pixel).
- `pix_cnt` updates at E16 of each pixel.
- `busy` is high from E0 until the edge at which the block re-enters IDLE.
- Ready is combinational from state and inputs. Valid must be held until accepted; data must be held stable while valid.

## Test plan
- Reset release, then `cmd_valid` held with 8'h11, rs=0, last=1 → `cmd_ready` first high on the 2nd edge after release. The bench must verify:
  - `lcd_data` is 0,0,0,1,0,0,0,1 over 8 cycles.
  - `lcd_cs` is low for exactly 8 cycles and `lcd_rs=0` during the word.
- Pixel 16'hF800 with `WORD_GAP=1` → 16 low-`lcd_cs` cycles, `lcd_rs=1`, bits 1,1,1,1,1 then eleven 0s. `pix_cnt` goes 0→1. The next `pix_ready` comes 2 cycles after `lcd_cs` rises.
- Burst 8'h2A(last=0), 00, 28, 01, 17(last=1) with `pix_valid` held high throughout → no pixel word appears until after the word 8'h17. The pixel then starts at the first IDLE cycle that follows.
- `cmd_valid` and `pix_valid` asserted in the same cycle → the command is serialized first and `pix_ready` stays 0 in that cycle.
- RAMWR followed by 65537 pixels → `pix_cnt` wraps to 0 then reads 1. A second RAMWR clears it to 0.
- `resetn` pulsed low at bit 5 of a pixel → immediately `lcd_cs=1`, `lcd_data=1`, `busy=0`, with no remaining bits after release. `lock` is clear and `pix_cnt=0` after release.

Source files
------------

// File: rtl/lcd_spi_arbiter.sv
// Shares the serial LCD bus between a command requester and a pixel requester,
// serializing each accepted word MSB first inside a low chip-select frame.
module lcd_spi_arbiter #(
   parameter int unsigned WORD_GAP = 1
) (
   input  logic        clk_27mhz,
   input  logic        resetn,
   input  logic        cmd_valid,
   input  logic        cmd_rs,
   input  logic [7:0]  cmd_data,
   input  logic        cmd_last,
   output logic        cmd_ready,
   input  logic        pix_valid,
   input  logic [15:0] pix_data,
   output logic        pix_ready,
   output logic        lcd_cs,
   output logic        lcd_rs,
   output logic        lcd_data,
   output logic        busy,
   output logic [15:0] pix_cnt
);
   localparam logic [3:0] GAP_LOAD = 4'(WORD_GAP);
   localparam logic [7:0] RAMWR    = 8'h2C;

   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

   state_t      state, state_nxt;
   logic        run;
   logic        lock;
   logic        word_pix;
   logic [15:0] shift_q;
   logic [4:0]  bit_cnt;
   logic [3:0]  gap_cnt;
   logic [15:0] pix_cnt_q;
   logic        cmd_acc;
   logic        pix_acc;
   logic        shift_done;
   logic        gap_done;

   // Commands always win; an open command burst also holds pixels off.
   assign cmd_ready  = run & (state == IDLE);
   assign pix_ready  = run & (state == IDLE) & ~cmd_valid & ~lock;
   assign cmd_acc    = cmd_valid & cmd_ready;
   assign pix_acc    = pix_valid & pix_ready;
   assign shift_done = (state == SHIFT) && (bit_cnt == 5'd1);
   assign gap_done   = (state == GAP) && (gap_cnt <= 4'd1);
   assign busy       = (state != IDLE);
   assign lcd_cs     = (state != SHIFT);
   assign lcd_data   = shift_q[15];
   assign pix_cnt    = pix_cnt_q;

   always_ff @(posedge clk_27mhz or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (cmd_acc || pix_acc) state_nxt = SHIFT;
         SHIFT:   if (shift_done) state_nxt = (GAP_LOAD == 4'd0) ? IDLE : GAP;
         GAP:     if (gap_done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // The shift register idles at all ones so lcd_data rests high; the 1-fill
   // brings it back to all ones exactly as the last bit leaves.
   always_ff @(posedge clk_27mhz or negedge resetn) begin
      if (!resetn) begin
         run       <= 1'b0;
         lock      <= 1'b0;
         word_pix  <= 1'b0;
         shift_q   <= '1;
         bit_cnt   <= '0;
         gap_cnt   <= '0;
         lcd_rs    <= 1'b1;
         pix_cnt_q <= '0;
      end else begin
         run <= 1'b1;
         if (cmd_acc) begin
            lock     <= ~cmd_last;
            shift_q  <= {cmd_data, 8'hFF};
            bit_cnt  <= 5'd8;
            lcd_rs   <= cmd_rs;
            word_pix <= 1'b0;
            if (!cmd_rs && (cmd_data == RAMWR)) pix_cnt_q <= '0;
         end else if (pix_acc) begin
            shift_q  <= pix_data;
            bit_cnt  <= 5'd16;
            lcd_rs   <= 1'b1;
            word_pix <= 1'b1;
         end else if (state == SHIFT) begin
            shift_q <= {shift_q[14:0], 1'b1};
            bit_cnt <= bit_cnt - 5'd1;
            if (shift_done) begin
               lcd_rs  <= 1'b1;
               gap_cnt <= GAP_LOAD;
               if (word_pix) pix_cnt_q <= pix_cnt_q + 16'd1;
            end
         end else if (state == GAP) begin
            gap_cnt <= gap_cnt - 4'd1;
         end
      end
   end
endmodule

// File: tb/tb_lcd_spi_arbiter.sv
// Directed bench for lcd_spi_arbiter: framing, bit order, priority, burst lock,
// pixel counting with wrap, and asynchronous reset mid-word.
module tb_lcd_spi_arbiter;
   logic        clk = 1'b0;
   logic        resetn;
   logic        cmd_valid, cmd_rs, cmd_last;
   logic [7:0]  cmd_data;
   logic        cmd_ready;
   logic        pix_valid;
   logic [15:0] pix_data;
   logic        pix_ready;
   logic        lcd_cs, lcd_rs, lcd_data, busy;
   logic [15:0] pix_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   lcd_spi_arbiter #(.WORD_GAP(1)) dut (
      .clk_27mhz(clk), .resetn(resetn),
      .cmd_valid(cmd_valid), .cmd_rs(cmd_rs), .cmd_data(cmd_data), .cmd_last(cmd_last),
      .cmd_ready(cmd_ready),
      .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
      .lcd_cs(lcd_cs), .lcd_rs(lcd_rs), .lcd_data(lcd_data),
      .busy(busy), .pix_cnt(pix_cnt)
   );

   always #5 clk = ~clk;

   // Drive-only helpers: start at a negedge in IDLE, end at a negedge back in IDLE.
   task automatic drive_cmd(input logic [7:0] d, input logic rs, input logic last);
      cmd_valid = 1'b1; cmd_data = d; cmd_rs = rs; cmd_last = last;
      @(posedge clk); #1 cmd_valid = 1'b0;
      repeat (8) @(posedge clk);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive_pixel(input logic [15:0] d);
      pix_valid = 1'b1; pix_data = d;
      @(posedge clk); #1 pix_valid = 1'b0;
      repeat (16) @(posedge clk);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      cmd_valid = 1'b1; cmd_data = 8'h11; cmd_rs = 1'b0; cmd_last = 1'b1;
      pix_valid = 1'b0; pix_data = 16'h0000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++; if (lcd_cs !== 1'b1)    begin n_fail++; $display("FAIL rst_cs: got %b want 1", lcd_cs); end
      n_checks++; if (lcd_rs !== 1'b1)    begin n_fail++; $display("FAIL rst_rs: got %b want 1", lcd_rs); end
      n_checks++; if (lcd_data !== 1'b1)  begin n_fail++; $display("FAIL rst_data: got %b want 1", lcd_data); end
      n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready); end
      n_checks++; if (pix_ready !== 1'b0) begin n_fail++; $display("FAIL rst_pix_ready: got %b want 0", pix_ready); end
      n_checks++; if (pix_cnt !== 16'h0)  begin n_fail++; $display("FAIL rst_pix_cnt: got %h want 0000", pix_cnt); end
      resetn = 1'b1;
      #1;
      n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL run_not_yet: got %b want 0", cmd_ready); end
   endtask

   task automatic test_command();
      logic [7:0] exp8;
      exp8 = 8'h11;
      @(posedge clk);
      @(negedge clk);
      n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL cmd_ready_2nd_edge: got %b want 1", cmd_ready); end
      @(posedge clk); #1 cmd_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         n_checks++; if (lcd_cs !== 1'b0) begin n_fail++; $display("FAIL cmd_cs_%0d: got %b want 0", i, lcd_cs); end
         n_checks++; if (lcd_rs !== 1'b0) begin n_fail++; $display("FAIL cmd_rs_%0d: got %b want 0", i, lcd_rs); end
         n_checks++; if (lcd_data !== exp8[7-i]) begin n_fail++; $display("FAIL cmd_bit_%0d: got %b want %b", i, lcd_data, exp8[7-i]); end
         @(posedge clk);
      end
      @(negedge clk);
      n_checks++; if (lcd_cs !== 1'b1)   begin n_fail++; $display("FAIL cmd_cs_end: got %b want 1", lcd_cs); end
      n_checks++; if (lcd_data !== 1'b1) begin n_fail++; $display("FAIL cmd_data_end: got %b want 1", lcd_data); end
      n_checks++; if (busy !== 1'b1)     begin n_fail++; $display("FAIL cmd_busy_gap: got %b want 1", busy); end
      @(posedge clk);
      @(negedge clk);
      n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL cmd_busy_idle: got %b want 0", busy); end
   endtask

   task automatic test_pixel();
      logic [15:0] exp16;
      exp16 = 16'hF800;
      n_checks++; if (pix_cnt !== 16'h0) begin n_fail++; $display("FAIL pix_cnt_before: got %h want 0000", pix_cnt); end
      pix_valid = 1'b1; pix_data = exp16;
      #1;
      n_checks++; if (pix_ready !== 1'b1) begin n_fail++; $display("FAIL pix_ready_idle: got %b want 1", pix_ready); end
      @(posedge clk); #1 pix_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         n_checks++; if (lcd_cs !== 1'b0) begin n_fail++; $display("FAIL pix_cs_%0d: got %b want 0", i, lcd_cs); end
         n_checks++; if (lcd_rs !== 1'b1) begin n_fail++; $display("FAIL pix_rs_%0d: got %b want 1", i, lcd_rs); end
         n_checks++; if (lcd_data !== exp16[15-i]) begin n_fail++; $display("FAIL pix_bit_%0d: got %b want %b", i, lcd_data, exp16[15-i]); end
         @(posedge clk);
      end
      @(negedge clk);
      n_checks++; if (lcd_cs !== 1'b1)    begin n_fail++; $display("FAIL pix_cs_end: got %b want 1", lcd_cs); end
      n_checks++; if (pix_cnt !== 16'd1)  begin n_fail++; $display("FAIL pix_cnt_one: got %h want 0001", pix_cnt); end
      n_checks++; if (pix_ready !== 1'b0) begin n_fail++; $display("FAIL pix_ready_gap: got %b want 0", pix_ready); end
      @(posedge clk);
      @(negedge clk);
      n_checks++; if (pix_ready !== 1'b1) begin n_fail++; $display("FAIL pix_ready_after_gap: got %b want 1", pix_ready); end
   endtask

   task automatic test_burst_lock();
      logic [7:0]  bw [5];
      logic        br [5];
      logic [15:0] exp16;
      bw = '{8'h2A, 8'h00, 8'h28, 8'h01, 8'h17};
      br = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      exp16 = 16'hA5C3;
      pix_valid = 1'b1; pix_data = exp16;
      for (int w = 0; w < 5; w++) begin
         cmd_valid = 1'b1; cmd_data = bw[w]; cmd_rs = br[w]; cmd_last = (w == 4);
         #1;
         n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL burst_cmd_ready_%0d: got %b want 1", w, cmd_ready); end
         n_checks++; if (pix_ready !== 1'b0) begin n_fail++; $display("FAIL burst_pix_ready_%0d: got %b want 0", w, pix_ready); end
         @(posedge clk); #1 cmd_valid = 1'b0;
         for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            n_checks++; if (lcd_rs !== br[w]) begin n_fail++; $display("FAIL burst_rs_%0d_%0d: got %b want %b", w, b, lcd_rs, br[w]); end
            n_checks++; if (lcd_data !== bw[w][7-b]) begin n_fail++; $display("FAIL burst_bit_%0d_%0d: got %b want %b", w, b, lcd_data, bw[w][7-b]); end
            @(posedge clk);
         end
         @(negedge clk);
         n_checks++; if (lcd_cs !== 1'b1) begin n_fail++; $display("FAIL burst_cs_end_%0d: got %b want 1", w, lcd_cs); end
         @(posedge clk);
         @(negedge clk);
         if (w < 4) begin
            n_checks++; if (pix_ready !== 1'b0) begin n_fail++; $display("FAIL burst_locked_%0d: got %b want 0", w, pix_ready); end
         end
      end
      n_checks++; if (pix_ready !== 1'b1) begin n_fail++; $display("FAIL burst_unlocked: got %b want 1", pix_ready); end
      @(posedge clk); #1 pix_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         n_checks++; if (lcd_cs !== 1'b0) begin n_fail++; $display("FAIL burst_pix_cs_%0d: got %b want 0", i, lcd_cs); end
         n_checks++; if (lcd_data !== exp16[15-i]) begin n_fail++; $display("FAIL burst_pix_bit_%0d: got %b want %b", i, lcd_data, exp16[15-i]); end
         @(posedge clk);
      end
      @(negedge clk);
      n_checks++; if (pix_cnt !== 16'd2) begin n_fail++; $display("FAIL burst_pix_cnt: got %h want 0002", pix_cnt); end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_simultaneous();
      pix_valid = 1'b1; pix_data = 16'h9234;
      cmd_valid = 1'b1; cmd_data = 8'h55; cmd_rs = 1'b0; cmd_last = 1'b1;
      #1;
      n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL sim_cmd_ready: got %b want 1", cmd_ready); end
      n_checks++; if (pix_ready !== 1'b0) begin n_fail++; $display("FAIL sim_pix_ready: got %b want 0", pix_ready); end
      @(posedge clk); #1 cmd_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (lcd_rs !== 1'b0)   begin n_fail++; $display("FAIL sim_first_rs: got %b want 0", lcd_rs); end
      n_checks++; if (lcd_data !== 1'b0) begin n_fail++; $display("FAIL sim_first_bit: got %b want 0", lcd_data); end
      repeat (8) @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      n_checks++; if (pix_ready !== 1'b1) begin n_fail++; $display("FAIL sim_pix_after: got %b want 1", pix_ready); end
      @(posedge clk); #1 pix_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (lcd_rs !== 1'b1)   begin n_fail++; $display("FAIL sim_pix_rs: got %b want 1", lcd_rs); end
      n_checks++; if (lcd_data !== 1'b1) begin n_fail++; $display("FAIL sim_pix_bit: got %b want 1", lcd_data); end
      repeat (16) @(posedge clk);
      @(negedge clk);
      n_checks++; if (pix_cnt !== 16'd3) begin n_fail++; $display("FAIL sim_pix_cnt: got %h want 0003", pix_cnt); end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_pix_cnt_wrap();
      drive_cmd(8'h2C, 1'b0, 1'b1);
      n_checks++; if (pix_cnt !== 16'h0) begin n_fail++; $display("FAIL ramwr_clear: got %h want 0000", pix_cnt); end
      // Skip ahead to the top of the count instead of streaming 65535 pixels.
      force dut.pix_cnt_q = 16'hFFFF;
      #1 release dut.pix_cnt_q;
      drive_pixel(16'h0001);
      n_checks++; if (pix_cnt !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero: got %h want 0000", pix_cnt); end
      drive_pixel(16'h0002);
      n_checks++; if (pix_cnt !== 16'h0001) begin n_fail++; $display("FAIL wrap_one: got %h want 0001", pix_cnt); end
      drive_cmd(8'h2C, 1'b1, 1'b1);
      n_checks++; if (pix_cnt !== 16'h0001) begin n_fail++; $display("FAIL param_2c_keeps: got %h want 0001", pix_cnt); end
      drive_cmd(8'h2C, 1'b0, 1'b1);
      n_checks++; if (pix_cnt !== 16'h0000) begin n_fail++; $display("FAIL ramwr_clear2: got %h want 0000", pix_cnt); end
   endtask

   task automatic test_reset_mid_word();
      int bad;
      drive_pixel(16'h1111);
      n_checks++; if (pix_cnt !== 16'd1) begin n_fail++; $display("FAIL mid_pre_cnt: got %h want 0001", pix_cnt); end
      pix_valid = 1'b1; pix_data = 16'hA5C3;
      @(posedge clk); #1 pix_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      n_checks++; if (lcd_cs !== 1'b0) begin n_fail++; $display("FAIL mid_pre_cs: got %b want 0", lcd_cs); end
      resetn = 1'b0; pix_valid = 1'b1; cmd_valid = 1'b1; cmd_data = 8'h01; cmd_rs = 1'b1; cmd_last = 1'b1;
      #1;
      n_checks++; if (lcd_cs !== 1'b1)    begin n_fail++; $display("FAIL mid_cs: got %b want 1", lcd_cs); end
      n_checks++; if (lcd_data !== 1'b1)  begin n_fail++; $display("FAIL mid_data: got %b want 1", lcd_data); end
      n_checks++; if (lcd_rs !== 1'b1)    begin n_fail++; $display("FAIL mid_rs: got %b want 1", lcd_rs); end
      n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy); end
      n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL mid_cmd_ready: got %b want 0", cmd_ready); end
      n_checks++; if (pix_ready !== 1'b0) begin n_fail++; $display("FAIL mid_pix_ready: got %b want 0", pix_ready); end
      n_checks++; if (pix_cnt !== 16'h0)  begin n_fail++; $display("FAIL mid_pix_cnt: got %h want 0000", pix_cnt); end
      @(negedge clk);
      resetn = 1'b1; pix_valid = 1'b0; cmd_valid = 1'b0;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (lcd_cs !== 1'b1 || busy !== 1'b0) bad++;
      end
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL mid_no_resume: got %0d active cycles want 0", bad); end
      // Lock an open burst, then reset during its first word.
      cmd_valid = 1'b1; cmd_data = 8'h2A; cmd_rs = 1'b0; cmd_last = 1'b0;
      @(posedge clk); #1 cmd_valid = 1'b0; pix_valid = 1'b1; pix_data = 16'h0F0F;
      repeat (3) @(posedge clk);
      #2 resetn = 1'b0;
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL lock_rst_busy: got %b want 0", busy); end
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_checks++; if (pix_ready !== 1'b1) begin n_fail++; $display("FAIL lock_cleared: got %b want 1", pix_ready); end
      n_checks++; if (pix_cnt !== 16'h0)  begin n_fail++; $display("FAIL lock_rst_cnt: got %h want 0000", pix_cnt); end
      @(posedge clk); #1 pix_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (lcd_cs !== 1'b0)   begin n_fail++; $display("FAIL post_rst_cs: got %b want 0", lcd_cs); end
      n_checks++; if (lcd_rs !== 1'b1)   begin n_fail++; $display("FAIL post_rst_rs: got %b want 1", lcd_rs); end
      n_checks++; if (lcd_data !== 1'b0) begin n_fail++; $display("FAIL post_rst_bit: got %b want 0", lcd_data); end
      repeat (20) @(posedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_command();
      test_pixel();
      test_burst_lock();
      test_simultaneous();
      test_pix_cnt_wrap();
      test_reset_mid_word();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
